// File: rtl/sram_checker_pkg.sv
// Shared types and defaults for the SRAM result checker.
// Holds the sweep FSM states, default widths and compare-mode encodings.
package sram_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_ADDR_W       = 16;
  localparam int unsigned DEF_DEPTH        = 480;
  localparam int unsigned DEF_REGION_SPLIT = 240;
  localparam int unsigned DEF_NUM_CH       = 2;
  localparam int unsigned DEF_CNT_W        = 16;

  localparam logic CMP_EXACT = 1'b0;
  localparam logic CMP_TOL   = 1'b1;

endpackage

// File: rtl/sram_result_checker_cmp_lane.sv
// Single-channel comparator: exact bitwise equality or signed |dut-gold| <= tol.
// Purely combinational; one instance per result channel.
module sram_cmp_lane
  import sram_checker_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] dut,
  input  logic [DATA_W-1:0] gold,
  input  logic              mode,
  input  logic [DATA_W-1:0] tol,
  output logic              mismatch
);

  logic [DATA_W:0] diff;
  logic [DATA_W:0] mag;

  always_comb begin
    // One extra bit so the difference of two extreme values cannot wrap.
    diff = {dut[DATA_W-1], dut} - {gold[DATA_W-1], gold};
    mag  = diff[DATA_W] ? -diff : diff;
    if (mode == CMP_EXACT) begin
      mismatch = (dut != gold);
    end else begin
      mismatch = (mag > {1'b0, tol});
    end
  end

endmodule

// File: rtl/sram_result_checker.sv
// Sweeps DUT result SRAMs against golden memories, counts per-region mismatches
// and measures DUT compute latency between start and finish strobes.
module sram_result_checker
  import sram_checker_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned REGION_SPLIT = DEF_REGION_SPLIT,
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     check_start,
  input  logic                     tol_mode,
  input  logic [DATA_W-1:0]        tol,
  output logic [ADDR_W-1:0]        dut_addr,
  input  logic [NUM_CH*DATA_W-1:0] dut_rdata,
  output logic [ADDR_W-1:0]        gold_addr,
  input  logic [NUM_CH*DATA_W-1:0] gold_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         region0_err,
  output logic [CNT_W-1:0]         region1_err,
  output logic                     first_err_valid,
  output logic [ADDR_W-1:0]        first_err_addr,
  input  logic                     dut_start,
  input  logic                     dut_finish,
  output logic [31:0]              cycle_count
);

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SplitAddr = ADDR_W'(REGION_SPLIT);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cmp_valid_q;
  logic [ADDR_W-1:0]   cmp_addr_q;
  logic                tol_mode_q;
  logic [DATA_W-1:0]   tol_q;
  logic                busy_q, done_q, pass_q;
  logic [CNT_W-1:0]    r0_q, r0_d, r1_q, r1_d;
  logic                fev_q, fev_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [31:0]         cyc_q;
  logic                armed_q;
  logic [NUM_CH-1:0]   lane_mis;
  logic                idx_mis;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    sram_cmp_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .dut     (dut_rdata[c*DATA_W +: DATA_W]),
      .gold    (gold_rdata[c*DATA_W +: DATA_W]),
      .mode    (tol_mode_q),
      .tol     (tol_q),
      .mismatch(lane_mis[c])
    );
  end

  // Any failing channel marks the whole index; it adds at most one error.
  assign idx_mis = cmp_valid_q & (|lane_mis);

  always_comb begin
    r0_d    = r0_q;
    r1_d    = r1_q;
    fev_d   = fev_q;
    first_d = first_q;
    if (idx_mis) begin
      if (cmp_addr_q < SplitAddr) begin
        if (r0_q != '1) r0_d = r0_q + 1'b1;
      end else begin
        if (r1_q != '1) r1_d = r1_q + 1'b1;
      end
      if (!fev_q) begin
        fev_d   = 1'b1;
        first_d = cmp_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      tol_mode_q <= CMP_EXACT;
      tol_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      r0_q       <= '0;
      r1_q       <= '0;
      fev_q      <= 1'b0;
      first_q    <= '0;
    end else begin
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      fev_q   <= fev_d;
      first_q <= first_d;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (check_start) begin
            state_q    <= StSweep;
            busy_q     <= 1'b1;
            addr_q     <= '0;
            tol_mode_q <= tol_mode;
            tol_q      <= tol;
            pass_q     <= 1'b0;
            r0_q       <= '0;
            r1_q       <= '0;
            fev_q      <= 1'b0;
            first_q    <= '0;
          end
        end
        StSweep: begin
          if (addr_q == LastAddr) state_q <= StDrain;
          else                    addr_q  <= addr_q + 1'b1;
        end
        StDrain: begin
          // Final compare lands this cycle, so judge pass on the next-state view.
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= ~fev_d;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      cmp_valid_q <= (state_q == StSweep);
      cmp_addr_q  <= addr_q;
    end
  end

  // Start wins over a coincident finish: clear and stay armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      armed_q <= 1'b0;
    end else if (dut_start) begin
      cyc_q   <= '0;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (dut_finish)  armed_q <= 1'b0;
    end
  end

  assign dut_addr        = addr_q;
  assign gold_addr       = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign region0_err     = r0_q;
  assign region1_err     = r1_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = first_q;
  assign cycle_count     = cyc_q;

endmodule

// File: tb/tb_sram_result_checker.sv
// Bench for sram_result_checker: table vectors, hand sequences and random sweeps
// scored against a behavioural model over the memory contents.
module tb_sram_result_checker;

  localparam int DEPTH = 480;
  localparam int SPLIT = 240;

  logic        clk = 1'b0;
  logic        rst, check_start, tol_mode, dut_start, dut_finish;
  logic [31:0] tol;

  logic [15:0] addr_a, gaddr_a, addr_b, gaddr_b;
  logic [63:0] drd_a, grd_a, drd_b, grd_b;
  logic        busy_a, done_a, pass_a, fev_a;
  logic        busy_b, done_b, pass_b, fev_b;
  logic [15:0] r0_a, r1_a, first_a, first_b;
  logic [3:0]  r0_b, r1_b;
  logic [31:0] cyc_a, cyc_b;

  logic [31:0] dmem [0:1][0:DEPTH-1];
  logic [31:0] gmem [0:1][0:DEPTH-1];

  int checks = 0;
  int failures = 0;

  int cap_r0, cap_r1, cap_first, cap_r0b, cap_r1b;
  bit cap_fev, cap_pass, cap_fevb, cap_passb;

  typedef struct {
    bit mode;
    int tol;
    int i0, c0, d0, i1, c1, d1, i2, c2, d2;
    int r0, r1;
    bit fev;
    int first;
    bit pass;
  } vec_t;

  vec_t vecs [6];

  sram_result_checker u_dut (
    .clk(clk), .rst(rst), .check_start(check_start), .tol_mode(tol_mode), .tol(tol),
    .dut_addr(addr_a), .dut_rdata(drd_a), .gold_addr(gaddr_a), .gold_rdata(grd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .region0_err(r0_a), .region1_err(r1_a),
    .first_err_valid(fev_a), .first_err_addr(first_a), .dut_start(dut_start),
    .dut_finish(dut_finish), .cycle_count(cyc_a)
  );

  sram_result_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .check_start(check_start), .tol_mode(tol_mode), .tol(tol),
    .dut_addr(addr_b), .dut_rdata(drd_b), .gold_addr(gaddr_b), .gold_rdata(grd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .region0_err(r0_b), .region1_err(r1_b),
    .first_err_valid(fev_b), .first_err_addr(first_b), .dut_start(dut_start),
    .dut_finish(dut_finish), .cycle_count(cyc_b)
  );

  always #5 clk = ~clk;

  // Registered-read memories, one-cycle latency.
  always @(posedge clk) begin
    drd_a <= {dmem[1][addr_a[8:0]], dmem[0][addr_a[8:0]]};
    grd_a <= {gmem[1][gaddr_a[8:0]], gmem[0][gaddr_a[8:0]]};
    drd_b <= {dmem[1][addr_b[8:0]], dmem[0][addr_b[8:0]]};
    grd_b <= {gmem[1][gaddr_b[8:0]], gmem[0][gaddr_b[8:0]]};
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic load_clean();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) begin
        logic [31:0] v;
        v = $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
        dmem[c][i] = v;
        gmem[c][i] = v;
      end
  endtask

  task automatic corrupt(input int i, input int c, input int d);
    if (d != 0) dmem[c][i] = dmem[c][i] + 32'(d);
  endtask

  // Reference: walk every index and apply the compare rules with wide arithmetic.
  task automatic model(input bit mode, input logic [31:0] t, output int r0, output int r1,
                       output bit fev, output int first);
    r0 = 0; r1 = 0; fev = 0; first = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bit bad;
      bad = 0;
      for (int c = 0; c < 2; c++) begin
        if (mode) begin
          longint d;
          d = longint'($signed(dmem[c][i])) - longint'($signed(gmem[c][i]));
          if (d < 0) d = -d;
          if (d > longint'(t)) bad = 1;
        end else if (dmem[c][i] != gmem[c][i]) begin
          bad = 1;
        end
      end
      if (bad) begin
        if (i < SPLIT) r0++; else r1++;
        if (!fev) begin fev = 1; first = i; end
      end
    end
  endtask

  task automatic run_sweep(input bit mode, input logic [31:0] t, input bit poke);
    int n;
    bit got;
    @(negedge clk);
    tol_mode = mode; tol = t; check_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_start = 1'b0; tol_mode = ~mode; tol = ~t;
    n = 1; got = 0;
    chk("busy_after_start", busy_a, 1);
    chk("addr_first", addr_a, 0);
    while (!got && n < 2000) begin
      if (n == 40) chk("addr_k39", addr_a, 39);
      if (poke && n == 50) check_start = 1'b1;
      if (poke && n == 51) check_start = 1'b0;
      if (done_a) got = 1;
      else begin @(negedge clk); n++; end
    end
    chk("done_cycle", n, DEPTH + 2);
    chk("busy_at_done", busy_a, 0);
    chk("sat_done_sync", done_b, 1);
    cap_r0 = r0_a; cap_r1 = r1_a; cap_first = first_a; cap_fev = fev_a; cap_pass = pass_a;
    cap_r0b = r0_b; cap_r1b = r1_b; cap_fevb = fev_b; cap_passb = pass_b;
    if (poke) check_start = 1'b1;
    @(negedge clk);
    check_start = 1'b0;
    chk("done_pulse", done_a, 0);
    if (poke) chk("restart_in_done_ignored", busy_a, 0);
  endtask

  task automatic check_results(input string tag, input int e_r0, input int e_r1,
                               input bit e_fev, input int e_first, input bit e_pass);
    chk({tag, "_r0"}, cap_r0, e_r0);
    chk({tag, "_r1"}, cap_r1, e_r1);
    chk({tag, "_fev"}, cap_fev, e_fev);
    chk({tag, "_first"}, cap_first, e_first);
    chk({tag, "_pass"}, cap_pass, e_pass);
    chk({tag, "_sat_r0"}, cap_r0b, sat15(e_r0));
    chk({tag, "_sat_r1"}, cap_r1b, sat15(e_r1));
    chk({tag, "_sat_pass"}, cap_passb, e_pass);
  endtask

  initial begin
    int e_r0, e_r1, e_first, seen, n, pre;
    bit e_fev;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{0, 0, 5, 0, 7, 5, 1, 3, 300, 1, -9, 1, 1, 1, 5, 0};
    vecs[2] = '{1, 1, 10, 0, 1, 20, 1, -2, 0, 0, 0, 1, 0, 1, 20, 0};
    vecs[3] = '{0, 0, 10, 0, 1, 20, 1, -2, 0, 0, 0, 2, 0, 1, 10, 0};
    vecs[4] = '{1, 2, 10, 0, 1, 20, 1, -2, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5] = '{1, 4, 239, 0, 5, 240, 1, -5, 479, 0, 1, 1, 1, 1, 239, 0};

    rst = 1'b1; check_start = 0; tol_mode = 0; tol = 0; dut_start = 0; dut_finish = 0;
    load_clean();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_fev", fev_a, 0);
    chk("rst_r0", r0_a, 0);
    chk("rst_r1", r1_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_cycle", cyc_a, 0);

    for (int v = 0; v < 6; v++) begin
      load_clean();
      corrupt(vecs[v].i0, vecs[v].c0, vecs[v].d0);
      corrupt(vecs[v].i1, vecs[v].c1, vecs[v].d1);
      corrupt(vecs[v].i2, vecs[v].c2, vecs[v].d2);
      run_sweep(vecs[v].mode, 32'(vecs[v].tol), v == 1);
      check_results($sformatf("vec%0d", v), vecs[v].r0, vecs[v].r1, vecs[v].fev,
                    vecs[v].first, vecs[v].pass);
      chk($sformatf("vec%0d_addr_hold", v), addr_a, DEPTH - 1);
    end

    // Extreme signed values: a difference that only fits in DATA_W+1 bits.
    load_clean();
    dmem[0][100] = 32'h7FFF_FFFF; gmem[0][100] = 32'h8000_0000;
    dmem[1][400] = 32'h8000_0000; gmem[1][400] = 32'h7FFF_FFFF;
    dmem[0][200] = 32'h8000_0000; gmem[0][200] = 32'h8000_0001;
    run_sweep(1'b1, 32'd1, 1'b0);
    check_results("extreme", 1, 1, 1, 100, 0);

    // Every index wrong: wide counters reach 240 each, 4-bit ones stick at 15.
    load_clean();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) gmem[c][i] = ~dmem[c][i];
    run_sweep(1'b0, 32'd0, 1'b0);
    check_results("all_bad", 240, 240, 1, 0, 0);

    for (int it = 0; it < 6; it++) begin
      bit m;
      logic [31:0] t;
      load_clean();
      for (int k = 0; k < int'($urandom_range(0, 25)); k++) begin
        int d;
        d = int'($urandom_range(1, 5));
        if ($urandom_range(0, 1) == 1) d = -d;
        corrupt(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 1)), d);
      end
      m = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 4);
      model(m, t, e_r0, e_r1, e_fev, e_first);
      run_sweep(m, t, it == 0);
      check_results($sformatf("rand%0d", it), e_r0, e_r1, e_fev, e_first, e_fev == 0);
    end

    // Reset mid-sweep.
    load_clean();
    for (int i = 0; i <= 90; i += 3) corrupt(i, 0, 1);
    pre = 0;
    for (int i = 0; i <= 97; i++) if (dmem[0][i] != gmem[0][i]) pre++;
    @(negedge clk);
    tol_mode = 0; check_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_start = 1'b0;
    n = 1;
    while (n < 100) begin @(negedge clk); n++; end
    chk("r0_before_rst", r0_a, pre);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_r0", r0_a, 0);
    chk("midrst_fev", fev_a, 0);
    chk("midrst_addr", addr_a, 0);
    seen = 0;
    repeat (600) begin @(negedge clk); if (done_a || done_b) seen++; end
    chk("midrst_no_done", seen, 0);

    // Latency counter.
    dut_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_start = 1'b0;
    repeat (999) @(posedge clk);
    @(negedge clk);
    dut_finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_finish = 1'b0;
    chk("lat_1000", cyc_a, 1000);
    repeat (10) @(negedge clk);
    chk("lat_disarmed", cyc_a, 1000);
    dut_start = 1'b1;
    @(negedge clk);
    dut_start = 1'b0;
    chk("lat_restart_clear", cyc_a, 0);
    repeat (5) @(negedge clk);
    chk("lat_5", cyc_a, 5);
    dut_start = 1'b1; dut_finish = 1'b1;
    @(negedge clk);
    dut_start = 1'b0; dut_finish = 1'b0;
    chk("lat_both_clear", cyc_a, 0);
    repeat (3) @(negedge clk);
    chk("lat_both_armed", cyc_a, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
